regfile_param: RTL and testbench

- Parametrised successor of the 8-bit MIPS register file: DATA_W-bit words, 2**ADDR_W registers, two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- All registers clear on asynchronous reset.
- Optional write-to-read bypass.
- Adds a sequential dump engine: streams every register out over a valid/ready handshake, for the debug/display path (LEDs, 7-segment, UART) of the LASD CPU.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_dump_fsm.sv | 110 +++++++++++
 rtl/regfile_param.sv | 109 ++++++++++
 tb/tb_regfile_param.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the parametrised register file and its dump engine.
//
//   Contents:
//     dump_state_t   - dump engine states (IDLE, SEND)
//     DEFAULT_ADDR_W - address width of the classic 8-register file
//     NREG           - register count of the classic file (1 << DEFAULT_ADDR_W)
//     REG_ZERO       - index of the hardwired-zero register
//     nreg_of()      - register count for an arbitrary address width
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  localparam int DEFAULT_ADDR_W = 3;
  localparam int NREG           = 1 << DEFAULT_ADDR_W;
  localparam int REG_ZERO       = 0;

  // A package cannot be parametrised, so modules with a non-default ADDR_W
  // derive their own register count through this helper.
  function automatic int nreg_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
//   Streams every register of the file, index 0 first, over a valid/ready
//   handshake. Each beat's data is captured into a holding register when the
//   beat is launched, so later writes to the array cannot disturb a beat that
//   is waiting for the consumer.
//
//   Ports:
//     clk, rst_n   - clock, asynchronous active-low reset
//     dump_start   - request a dump; only looked at while IDLE
//     dump_ready   - consumer accepts the current beat
//     rdata        - bypassed array value at raddr (from the parent's read mux)
//     raddr        - array index the next beat will be captured from
//     dump_busy    - engine not IDLE
//     dump_valid   - dump_addr/dump_data hold a beat
//     dump_addr    - index of the current beat
//     dump_data    - captured value of register dump_addr
//     dump_done    - one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  // The last register index is all ones for any power-of-two register count.
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  dump_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic [DATA_W-1:0] data_reg,  data_next;
  logic              done_reg,  done_next;

  // While IDLE the only beat that can be launched is index 0; while sending,
  // the only one is the successor of the current beat. Pointing the read mux
  // there permanently means the capture below needs no extra select logic.
  // At LAST_ADDR the increment wraps, but that value is never captured.
  assign raddr = (state_reg == IDLE) ? ADDR_W'(REG_ZERO) : addr_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // A start that coincides with the done pulse lands here too, so a
        // new dump can follow the previous one without a gap cycle.
        if (dump_start) begin
          state_next = SEND;
          addr_next  = ADDR_W'(REG_ZERO);
          data_next  = rdata;
        end
      end

      SEND: begin
        // Without a handshake everything holds, which keeps the beat stable.
        if (dump_ready) begin
          if (addr_reg == LAST_ADDR) begin
            // dump_addr deliberately keeps the last index after the dump.
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            addr_next = addr_reg + 1'b1;
            data_next = rdata;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dump_busy  = (state_reg != IDLE);
  assign dump_valid = (state_reg == SEND);
  assign dump_done  = done_reg;
  assign dump_addr  = addr_reg;
  assign dump_data  = data_reg;

endmodule

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//   Parametrised register file: 2**ADDR_W registers of DATA_W bits, two
//   combinational read ports, one synchronous write port, register 0
//   hardwired to zero, optional write-to-read bypass, plus a dump engine that
//   streams the whole file out for the debug/display path.
//
//   Parameters:
//     DATA_W - word width
//     ADDR_W - address width (register count is 2**ADDR_W)
//     BYPASS - 1: reading the address written this cycle returns wd3
//              0: it returns the stored value
//
//   Ports:
//     clk, rst_n           - clock, asynchronous active-low reset
//     we3, wa3, wd3        - write enable / address / data
//     ra1, rd1, ra2, rd2   - read ports (combinational)
//     dump_start           - request a full dump (ignored while busy)
//     dump_busy            - dump engine active
//     dump_valid/ready     - beat handshake
//     dump_addr/dump_data  - current beat index and captured value
//     dump_done            - one-cycle pulse after the last beat
// -----------------------------------------------------------------------------
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int NUM_REGS  = nreg_of(ADDR_W);
  localparam int NUM_RPORT = 3;  // rd1, rd2 and the dump engine

  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  logic [ADDR_W-1:0] dump_raddr;
  logic [DATA_W-1:0] dump_rdata;

  // Storage. Entry 0 is cleared by reset and never written, and the read
  // muxes force it to zero anyway, so synthesis may trim it away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we3 && (wa3 != ADDR_W'(REG_ZERO))) begin
      regs_reg[wa3] <= wd3;
    end
  end

  // Three identical read muxes. The zero test is applied last so that a
  // write aimed at register 0 can never leak through the bypass path.
  for (genvar gi = 0; gi < NUM_RPORT; gi++) begin : g_rport
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = (gi == 0) ? ra1 : (gi == 1) ? ra2 : dump_raddr;

    always_comb begin
      data = regs_reg[addr];
      if ((BYPASS != 0) && we3 && (addr == wa3)) begin
        data = wd3;
      end
      if (addr == ADDR_W'(REG_ZERO)) begin
        data = '0;
      end
    end
  end

  assign rd1        = g_rport[0].data;
  assign rd2        = g_rport[1].data;
  assign dump_rdata = g_rport[2].data;

  regfile_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .rdata      (dump_rdata),
    .raddr      (dump_raddr),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

endmodule

// File: tb/tb_regfile_param.sv
`timescale 1ns/1ps
module tb_regfile_param;

  typedef struct {
    int addr;
    int data;
    int data_nb;
    int cyc;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we3 = 1'b0;
  logic [2:0] wa3 = '0;
  logic [7:0] wd3 = '0;
  logic [2:0] ra1 = '0;
  logic [2:0] ra2 = '0;
  logic       dump_start = 1'b0;
  logic       dump_ready = 1'b0;

  logic [7:0] rd1, rd2, dump_data;
  logic [2:0] dump_addr;
  logic       dump_busy, dump_valid, dump_done;

  logic [7:0] rd1_nb, rd2_nb, data_nb;
  logic [2:0] addr_nb;
  logic       busy_nb, valid_nb, done_nb;

  logic        w_we = 1'b0;
  logic [3:0]  w_wa = '0;
  logic [15:0] w_wd = '0;
  logic [3:0]  w_ra1 = '0;
  logic [3:0]  w_ra2 = '0;
  logic        w_start = 1'b0;
  logic        w_ready = 1'b0;
  logic [15:0] w_rd1, w_rd2, w_data;
  logic [3:0]  w_addr;
  logic        w_busy, w_valid, w_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int w_done_count = 0;
  int w_done_cyc = 0;
  beat_t beats[$];
  beat_t w_beats[$];

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .dump_start(dump_start), .dump_busy(busy_nb), .dump_valid(valid_nb),
    .dump_ready(dump_ready), .dump_addr(addr_nb), .dump_data(data_nb),
    .dump_done(done_nb)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .we3(w_we), .wa3(w_wa), .wd3(w_wd),
    .ra1(w_ra1), .ra2(w_ra2), .rd1(w_rd1), .rd2(w_rd2),
    .dump_start(w_start), .dump_busy(w_busy), .dump_valid(w_valid),
    .dump_ready(w_ready), .dump_addr(w_addr), .dump_data(w_data),
    .dump_done(w_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 8-bit file ----------------
  logic [7:0] m_reg [8];
  bit         m_busy;
  int         m_addr;
  logic [7:0] m_data, m_data_nb;
  bit         m_done;

  function automatic logic [7:0] m_rsel(input int a, input bit byp);
    if (a == 0) return 8'h00;
    if (byp && we3 && a == int'(wa3)) return wd3;
    return m_reg[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 8'h00;
      m_busy <= 1'b0; m_addr <= 0; m_data <= 8'h00; m_data_nb <= 8'h00; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (dump_start) begin
          m_busy <= 1'b1; m_addr <= 0; m_data <= 8'h00; m_data_nb <= 8'h00;
        end
      end else if (dump_ready) begin
        if (m_addr == 7) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_addr    <= m_addr + 1;
          m_data    <= m_rsel(m_addr + 1, 1'b1);
          m_data_nb <= m_rsel(m_addr + 1, 1'b0);
        end
      end
      if (we3 && wa3 != 3'd0) m_reg[wa3] <= wd3;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-cycle compare and beat logging ----------------
  always @(negedge clk) begin
    chk("rd1", rd1, m_rsel(int'(ra1), 1'b1));
    chk("rd2", rd2, m_rsel(int'(ra2), 1'b1));
    chk("rd1_nb", rd1_nb, m_rsel(int'(ra1), 1'b0));
    chk("rd2_nb", rd2_nb, m_rsel(int'(ra2), 1'b0));
    chk("dump_valid", dump_valid, m_busy);
    chk("dump_busy", dump_busy, m_busy);
    chk("dump_done", dump_done, m_done);
    chk("valid_nb", valid_nb, m_busy);
    chk("done_nb", done_nb, m_done);
    if (m_busy) begin
      chk("dump_addr", dump_addr, m_addr);
      chk("dump_data", dump_data, m_data);
      chk("addr_nb", addr_nb, m_addr);
      chk("data_nb", data_nb, m_data_nb);
    end
    if (dump_valid && dump_ready)
      beats.push_back('{int'(dump_addr), int'(dump_data), int'(data_nb), cyc});
    if (dump_done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (w_valid && w_ready)
      w_beats.push_back('{int'(w_addr), int'(w_data), 0, cyc});
    if (w_done) begin
      w_done_count++;
      w_done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit wide, input int base, input int limit);
    int n = 0;
    while ((wide ? w_done_count : done_count) == base && n < limit) begin
      tick();
      n++;
    end
    chk(wide ? "w_done_timeout" : "done_timeout",
        (wide ? w_done_count : done_count) != base, 1);
  endtask

  initial begin
    int start_cyc;
    int dc;

    repeat (3) tick();
    rst_n = 1'b1;
    #1 chk("reset_rd1_r0", rd1, 8'h00);
    chk("reset_valid", dump_valid, 1'b0);
    chk("reset_addr", dump_addr, 3'd0);

    // write r3 = 0x5A, visible next cycle
    we3 = 1'b1; wa3 = 3'd3; wd3 = 8'h5A;
    tick();
    we3 = 1'b0; ra1 = 3'd3;
    #1 chk("write_r3", rd1, 8'h5A);

    // writes to r0 are discarded
    we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hAA; ra1 = 3'd0;
    tick();
    we3 = 1'b0;
    #1 chk("r0_stays_zero", rd1, 8'h00);

    // same-cycle read of the address being written
    we3 = 1'b1; wa3 = 3'd3; wd3 = 8'h77; ra2 = 3'd3;
    #1 chk("bypass_rd2", rd2, 8'h77);
    chk("nobypass_rd2", rd2_nb, 8'h5A);
    tick();
    we3 = 1'b0;

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra1 = 3'(2 * i); ra2 = 3'(2 * i + 1);
      #1 chk("async_rst_rd1", rd1, 8'h00);
      chk("async_rst_rd2", rd2, 8'h00);
    end
    tick();
    rst_n = 1'b1;

    // load r1..r7 = 0x11..0x77
    for (int i = 1; i < 8; i++) begin
      we3 = 1'b1; wa3 = 3'(i); wd3 = 8'(i * 17);
      tick();
    end
    we3 = 1'b0;

    // full dump with ready held high
    beats.delete();
    dc = done_count;
    dump_ready = 1'b1; dump_start = 1'b1;
    start_cyc = cyc;
    tick();
    dump_start = 1'b0;
    wait_done(1'b0, dc, 20);
    chk("dump_beats", beats.size(), 8);
    if (beats.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("stream_addr", beats[i].addr, i);
        chk("stream_data", beats[i].data, i * 17);
        chk("stream_cyc", beats[i].cyc, start_cyc + 1 + i);
      end
    end
    chk("done_latency", done_cyc - start_cyc, 9);
    repeat (2) tick();
    chk("done_once", done_count, dc + 1);

    // backpressure at beat 2, same-edge write at beat 3, start at beat 5
    beats.delete();
    dc = done_count;
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    dump_ready = 1'b0; we3 = 1'b1; wa3 = 3'd2; wd3 = 8'hEE;
    repeat (3) begin
      #1 chk("hold_addr", dump_addr, 3'd2);
      chk("hold_data", dump_data, 8'h22);
      tick();
    end
    dump_ready = 1'b1; we3 = 1'b0;
    #1 chk("hold_data_end", dump_data, 8'h22);
    tick();
    we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h99;
    tick();
    we3 = 1'b0;
    #1 chk("beat4_addr", dump_addr, 3'd4);
    chk("beat4_bypass", dump_data, 8'h99);
    chk("beat4_nobypass", data_nb, 8'h44);
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    wait_done(1'b0, dc, 20);
    chk("bp_beats", beats.size(), 8);
    if (beats.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("bp_addr", beats[i].addr, i);
      chk("bp_beat2", beats[2].data, 8'h22);
      chk("bp_beat4", beats[4].data, 8'h99);
      chk("bp_beat7", beats[7].data, 8'h77);
    end
    repeat (3) tick();
    chk("no_restart", dump_busy, 1'b0);
    chk("bp_done_once", done_count, dc + 1);

    // start during the done pulse, then abort by reset at beat 4
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (8) tick();
    #1 chk("done_pulse", dump_done, 1'b1);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    #1 chk("restart_valid", dump_valid, 1'b1);
    chk("restart_addr", dump_addr, 3'd0);
    repeat (4) tick();
    dc = done_count;
    chk("abort_at_beat4", dump_addr, 3'd4);
    #1 rst_n = 1'b0;
    #1 chk("abort_valid", dump_valid, 1'b0);
    chk("abort_busy", dump_busy, 1'b0);
    chk("abort_done", dump_done, 1'b0);
    ra1 = 3'd4; ra2 = 3'd7;
    #1 chk("abort_rd1", rd1, 8'h00);
    chk("abort_rd2", rd2, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_no_done", done_count, dc);

    // 16-bit / 16-register instance
    w_we = 1'b1; w_wa = 4'd15; w_wd = 16'hBEEF;
    tick();
    w_we = 1'b0; w_ra1 = 4'd15;
    #1 chk("w_rd1", w_rd1, 16'hBEEF);
    chk("w_rd2", w_rd2, 16'h0000);
    w_beats.delete();
    dc = w_done_count;
    w_ready = 1'b1; w_start = 1'b1;
    start_cyc = cyc;
    tick();
    w_start = 1'b0;
    wait_done(1'b1, dc, 40);
    chk("w_beats", w_beats.size(), 16);
    if (w_beats.size() == 16) begin
      chk("w_beat0", w_beats[0].data, 0);
      chk("w_beat15_addr", w_beats[15].addr, 15);
      chk("w_beat15_data", w_beats[15].data, 16'hBEEF);
    end
    chk("w_latency", w_done_cyc - start_cyc, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
